dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Sequencing and arbitration controller in front of the single-port data memory. It shares the memory between the core LSU port and the UART loader port, converts each accepted request into one registered memory access cycle (active-low chip select, write enable, byte mask), and returns registered read data or a write acknowledge to the requester. It sits between the LSU/UART-loader and the data memory, and owns all memory control pins.

Parameters:
DEPTH, 256, number of 32-bit words in data memory; addresses >= DEPTH are out-of-range
STARVE_LIMIT, 4, consecutive core accepts while uart_req is pending before the UART is forced to win
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk_o  in  1  system clock, all state on posedge
reset  in  1  asynchronous active-low reset
boot_mode  in  1  1 = UART-only ownership (core never granted)
core_req  in  1  core request valid; fields held until core_gnt
core_we  in  1  1 = store, 0 = load
core_addr  in  32  word address
core_wdata  in  32  store data
core_mask  in  4  byte-lane store mask
core_gnt  out  1  combinational accept; transfer occurs at posedge with req&gnt
core_valid  out  1  one-cycle response pulse
core_rdata  out  32  load data, valid with core_valid
core_err  out  1  out-of-range flag, valid with core_valid
uart_req/uart_we/uart_addr/uart_wdata/uart_mask  in  1/1/32/32/4  as core_*
uart_last  in  1  last beat of UART burst
uart_gnt/uart_valid/uart_rdata/uart_err  out  1/1/32/1  as core_*
mem_addrL  out  32  load address to memory
mem_addrS  out  32  store address to memory
mem_store  out  32  store data to memory
mem_mask  out  4  byte mask to memory
mem_wr_E  out  1  1 = write cycle
mem_cs_E  out  1  active-low chip select
mem_on  out  1  memory enable
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async, reset=0): cmd register cleared, state IDLE, mem_cs_E=1, mem_wr_E=0, mem_mask=0, mem_addrL/S=0, mem_store=0, mem_on=0, all gnt/valid/err=0, rdata=0, starve counter=0, burst lock=0. Access in flight is aborted: cs_E goes high immediately, no valid is issued. mem_on=1 from first posedge after reset release.
- States: IDLE (no access this cycle), ACC (memory driven from cmd register). Transition at every posedge: to ACC if a transfer was accepted, else IDLE. Throughput 1 access/cycle; a new accept may occur during ACC.
- Arbitration (combinational, one winner max): boot_mode=1 -> UART only. Else if burst lock -> UART only. Else if starve counter == STARVE_LIMIT and uart_req -> UART. Else core has priority, UART wins when core_req=0.
- Starve counter: +1 per core accept while uart_req=1; cleared on UART accept or uart_req=0; saturates at STARVE_LIMIT.
- Burst lock: set on UART accept with uart_last=0; cleared on UART accept with uart_last=1 or when boot_mode is deasserted.
- Accept at edge E0: latch {src, we, addr, wdata, mask}. Cycle E0->E1 (ACC): mem_addrL=mem_addrS=addr, mem_store=wdata, mem_wr_E=we, mem_mask=we?mask:0, mem_cs_E=0. The write commits at the memory's negedge within ACC.
- Edge E1: x_valid=1 for one cycle, x_rdata=mem_rdata for loads and 0 for stores. Latency: response visible in the cycle after ACC (2 edges after accept).
- Out-of-range (addr >= DEPTH): accepted; ACC keeps mem_cs_E=1 and mem_wr_E=0; response valid with err=1 and rdata=0. No memory write occurs.
- Outside ACC: mem_cs_E=1, mem_wr_E=0, mem_mask=0; address and data outputs hold their last values.
- Simultaneous core and UART req: exactly one gnt. The loser keeps req high and is not granted a stale response.
- boot_mode change mid-burst: affects arbitration only from the next cycle. An access already accepted completes normally.

Decomposition:
- Package dmem_arb_pkg: owner_e {OWN_CORE, OWN_UART}; state_e {IDLE, ACC}; dmem_cmd_t struct {src, we, addr[31:0], wdata[31:0], mask[3:0]}; localparam for the DEPTH default.
- Sub-module dmem_arb_sel: combinational winner select from req, boot_mode, lock, starve-counter flags. The top level holds all registers.

Test Plan:
- Reset released, no reqs -> mem_cs_E=1, mem_on=1 after first edge, all valids 0.
- Core store addr=5, wdata=0xDEADBEEF, mask=4'b0011, then load addr=5 -> load rdata=(old word & 0xFFFF0000)|0xBEEF, core_valid 2 edges after each accept.
- Core and UART req continuously, STARVE_LIMIT=4 -> grant pattern C,C,C,C,U repeating; never two gnts in one cycle.
- boot_mode=1, UART burst of 3 writes (uart_last on 3rd) with core_req high -> core_gnt=0 throughout, 3 back-to-back ACC cycles, words written.
- Load addr=300 -> mem_cs_E stays 1, core_valid with core_err=1, core_rdata=0; store addr=256 -> no memory change.
- Reset asserted during ACC of store -> mem_cs_E=1 immediately, no valid; after release, next request serviced normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The command register records who owns the access in flight and what it does.
package dmem_arb_pkg;

    localparam int DMEM_DEPTH        = 256;
    localparam int DMEM_STARVE_LIMIT = 4;

    typedef enum logic {
        OWN_CORE,
        OWN_UART
    } owner_e;

    typedef enum logic {
        IDLE,
        ACC
    } state_e;

    typedef struct packed {
        owner_e      src;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dmem_cmd_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational winner select between the core LSU and the UART loader.
// At most one grant is ever asserted.
module dmem_arb_sel (
    input  logic core_req,
    input  logic uart_req,
    input  logic boot_mode,
    input  logic lock,
    input  logic starve_full,
    output logic core_gnt,
    output logic uart_gnt
);

    logic uart_only;

    // A full starvation counter only matters while the UART is actually waiting.
    assign uart_only = boot_mode | lock | (starve_full & uart_req);
    assign core_gnt  = core_req & ~uart_only;
    assign uart_gnt  = uart_req & (uart_only | ~core_req);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU and the UART loader.
// Handshake: a request transfers at the posedge where req and gnt are both high; gnt is combinational.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH        = DMEM_DEPTH,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT,
    parameter int CNT_W        = 3
) (
    input  logic        clk_o,
    input  logic        reset,
    input  logic        boot_mode,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_mask,
    output logic        core_gnt,
    output logic        core_valid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        uart_req,
    input  logic        uart_we,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_mask,
    input  logic        uart_last,
    output logic        uart_gnt,
    output logic        uart_valid,
    output logic [31:0] uart_rdata,
    output logic        uart_err,
    output logic [31:0] mem_addrL,
    output logic [31:0] mem_addrS,
    output logic [31:0] mem_store,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_E,
    output logic        mem_cs_E,
    output logic        mem_on,
    input  logic [31:0] mem_rdata,
    output state_e      dbg_state
);

    state_e           state_q, state_d;
    dmem_cmd_t        cmd_q, cmd_d;
    logic [CNT_W-1:0] starve_q;
    logic             lock_q, boot_q;
    logic             core_acc, uart_acc, acc, starve_full;
    logic             cmd_in_range, acc_live, resp, resp_data_ok;

    assign starve_full = (starve_q == CNT_W'(STARVE_LIMIT));

    dmem_arb_sel u_sel (
        .core_req    (core_req),
        .uart_req    (uart_req),
        .boot_mode   (boot_mode),
        .lock        (lock_q),
        .starve_full (starve_full),
        .core_gnt    (core_gnt),
        .uart_gnt    (uart_gnt)
    );

    always_comb begin
        core_acc = core_req & core_gnt;
        uart_acc = uart_req & uart_gnt;
        acc      = core_acc | uart_acc;
        cmd_d    = cmd_q;
        if (uart_acc) begin
            cmd_d.src   = OWN_UART;
            cmd_d.we    = uart_we;
            cmd_d.addr  = uart_addr;
            cmd_d.wdata = uart_wdata;
            cmd_d.mask  = uart_mask;
        end else if (core_acc) begin
            cmd_d.src   = OWN_CORE;
            cmd_d.we    = core_we;
            cmd_d.addr  = core_addr;
            cmd_d.wdata = core_wdata;
            cmd_d.mask  = core_mask;
        end
        state_d = acc ? ACC : IDLE;
    end

    // Memory pins come straight from registers; address/data hold between accesses.
    assign cmd_in_range = (cmd_q.addr < 32'(DEPTH));
    assign acc_live     = (state_q == ACC) && cmd_in_range;
    assign mem_addrL    = cmd_q.addr;
    assign mem_addrS    = cmd_q.addr;
    assign mem_store    = cmd_q.wdata;
    assign mem_cs_E     = ~acc_live;
    assign mem_wr_E     = acc_live & cmd_q.we;
    assign mem_mask     = (acc_live && cmd_q.we) ? cmd_q.mask : 4'b0000;
    assign dbg_state    = state_q;

    assign resp         = (state_q == ACC);
    assign resp_data_ok = resp && !cmd_q.we && cmd_in_range;

    always_ff @(posedge clk_o or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            starve_q   <= '0;
            lock_q     <= 1'b0;
            boot_q     <= 1'b0;
            mem_on     <= 1'b0;
            core_valid <= 1'b0;
            core_rdata <= '0;
            core_err   <= 1'b0;
            uart_valid <= 1'b0;
            uart_rdata <= '0;
            uart_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            mem_on  <= 1'b1;
            boot_q  <= boot_mode;

            core_valid <= resp && (cmd_q.src == OWN_CORE);
            core_err   <= resp && (cmd_q.src == OWN_CORE) && !cmd_in_range;
            core_rdata <= (resp_data_ok && cmd_q.src == OWN_CORE) ? mem_rdata : 32'h0;
            uart_valid <= resp && (cmd_q.src == OWN_UART);
            uart_err   <= resp && (cmd_q.src == OWN_UART) && !cmd_in_range;
            uart_rdata <= (resp_data_ok && cmd_q.src == OWN_UART) ? mem_rdata : 32'h0;

            if (uart_acc || !uart_req) begin
                starve_q <= '0;
            end else if (core_acc && !starve_full) begin
                starve_q <= starve_q + CNT_W'(1);
            end

            // Leaving boot mode drops any half-finished burst lock.
            if (boot_q && !boot_mode) begin
                lock_q <= 1'b0;
            end else if (uart_acc) begin
                lock_q <= ~uart_last;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-masked memory attached.
// Single core transfers come from a vector table; arbitration and reset cases are hand sequences.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        boot_mode = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [3:0]  core_mask = '0;
    logic        core_gnt, core_valid, core_err;
    logic [31:0] core_rdata;
    logic        uart_req = 1'b0, uart_we = 1'b0, uart_last = 1'b0;
    logic [31:0] uart_addr = '0, uart_wdata = '0;
    logic [3:0]  uart_mask = '0;
    logic        uart_gnt, uart_valid, uart_err;
    logic [31:0] uart_rdata;
    logic [31:0] mem_addrL, mem_addrS, mem_store, mem_rdata;
    logic [3:0]  mem_mask;
    logic        mem_wr_E, mem_cs_E, mem_on;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_o(clk), .reset(reset), .boot_mode(boot_mode),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_mask(core_mask), .core_gnt(core_gnt),
        .core_valid(core_valid), .core_rdata(core_rdata), .core_err(core_err),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr),
        .uart_wdata(uart_wdata), .uart_mask(uart_mask), .uart_last(uart_last),
        .uart_gnt(uart_gnt), .uart_valid(uart_valid), .uart_rdata(uart_rdata),
        .uart_err(uart_err), .mem_addrL(mem_addrL), .mem_addrS(mem_addrS),
        .mem_store(mem_store), .mem_mask(mem_mask), .mem_wr_E(mem_wr_E),
        .mem_cs_E(mem_cs_E), .mem_on(mem_on), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // Memory model: index by low 8 bits so a stray write at 256 would land on word 0.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addrL[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        forever begin
            @(negedge clk);
            if (!mem_cs_E && mem_wr_E) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_addrS[7:0]][8*b +: 8] <= mem_store[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a posedge with the bus idle; leaves just after a posedge.
    task automatic core_xfer(input vec_t v);
        logic live;
        live = (v.addr < 32'd256);
        core_req = 1'b1; core_we = v.we; core_addr = v.addr;
        core_wdata = v.wdata; core_mask = v.mask;
        #1;
        check("core_gnt", 32'(core_gnt), 32'd1);
        @(posedge clk); #1;
        core_req = 1'b0;
        check("acc_cs_E", 32'(mem_cs_E), live ? 32'd0 : 32'd1);
        check("acc_wr_E", 32'(mem_wr_E), 32'(live && v.we));
        check("acc_mask", 32'(mem_mask), (live && v.we) ? 32'(v.mask) : 32'd0);
        check("acc_addr", mem_addrL, v.addr);
        @(posedge clk); #1;
        check("core_valid", 32'(core_valid), 32'd1);
        check("core_rdata", core_rdata, v.exp_rdata);
        check("core_err", 32'(core_err), 32'(v.exp_err));
        check("uart_valid_quiet", 32'(uart_valid), 32'd0);
        @(posedge clk); #1;
        check("core_valid_pulse", 32'(core_valid), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'd5,   32'hDEADBEEF, 4'b0011, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'd5,   32'h0,        4'b0000, 32'hA5A5BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd6,   32'h12345678, 4'b1100, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'd6,   32'h0,        4'b0000, 32'h12340006, 1'b0};
        vecs[4]  = '{1'b1, 32'd7,   32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'd7,   32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b0, 32'd255, 32'h0,        4'b0000, 32'hA5A500FF, 1'b0};
        vecs[7]  = '{1'b0, 32'd300, 32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'd256, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'd0,   32'h0,        4'b0000, 32'hA5A50000, 1'b0};
        vecs[10] = '{1'b1, 32'd255, 32'h00000011, 4'b0001, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'd255, 32'h0,        4'b0000, 32'hA5A50011, 1'b0};

        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_cs_E", 32'(mem_cs_E), 32'd1);
        check("rst_wr_E", 32'(mem_wr_E), 32'd0);
        check("rst_mem_on", 32'(mem_on), 32'd0);
        check("rst_valids", 32'({core_valid, uart_valid}), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("boot_mem_on", 32'(mem_on), 32'd1);
        check("boot_cs_E", 32'(mem_cs_E), 32'd1);
        check("boot_valids", 32'({core_valid, uart_valid}), 32'd0);

        for (int i = 0; i < 12; i++) core_xfer(vecs[i]);

        // Continuous contention: four core wins, then the UART is forced through.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'd1;
        uart_req = 1'b1; uart_we = 1'b0; uart_addr = 32'd2; uart_last = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("starve_core_gnt", 32'(core_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
            check("starve_uart_gnt", 32'(uart_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        core_req = 1'b0; uart_req = 1'b0;
        idle(3);

        // Burst lock in normal mode holds off the core until uart_last.
        uart_req = 1'b1; uart_last = 1'b0; uart_addr = 32'd3;
        #1;
        check("lock_first_uart", 32'(uart_gnt), 32'd1);
        @(posedge clk); #1;
        core_req = 1'b1; uart_last = 1'b1;
        #1;
        check("lock_hold_uart", 32'(uart_gnt), 32'd1);
        check("lock_hold_core", 32'(core_gnt), 32'd0);
        @(posedge clk); #1;
        check("lock_free_core", 32'(core_gnt), 32'd1);
        check("lock_free_uart", 32'(uart_gnt), 32'd0);
        core_req = 1'b0; uart_req = 1'b0;
        idle(3);

        // Boot-mode burst of three writes with the core asking the whole time.
        boot_mode = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'd10;
        uart_we = 1'b1; uart_mask = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            if (b < 3) begin
                uart_req = 1'b1; uart_addr = 32'(20 + b);
                uart_wdata = 32'h0BAD_0000 | 32'(b); uart_last = (b == 2);
            end else begin
                uart_req = 1'b0;
            end
            #1;
            check("boot_core_gnt", 32'(core_gnt), 32'd0);
            if (b < 3) check("boot_uart_gnt", 32'(uart_gnt), 32'd1);
            if (b >= 1 && b <= 3) begin
                check("boot_cs_E", 32'(mem_cs_E), 32'd0);
                check("boot_addrS", mem_addrS, 32'(20 + b - 1));
            end
            if (b >= 2) begin
                check("boot_uart_valid", 32'(uart_valid), 32'd1);
                check("boot_uart_rdata", uart_rdata, 32'd0);
            end
            @(posedge clk); #1;
        end
        check("boot_idle_cs_E", 32'(mem_cs_E), 32'd1);
        check("boot_last_valid", 32'(uart_valid), 32'd0);
        for (int w = 0; w < 3; w++) check("boot_word", mem[20 + w], 32'h0BAD_0000 | 32'(w));
        boot_mode = 1'b0;
        #1;
        check("post_boot_core_gnt", 32'(core_gnt), 32'd1);
        @(posedge clk); #1;
        core_req = 1'b0;
        idle(3);

        // Reset during the ACC cycle of a store aborts it.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'd40;
        core_wdata = 32'h11111111; core_mask = 4'b1111;
        @(posedge clk); #1;
        core_req = 1'b0;
        check("abort_cs_live", 32'(mem_cs_E), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_cs_E", 32'(mem_cs_E), 32'd1);
        check("abort_wr_E", 32'(mem_wr_E), 32'd0);
        @(posedge clk); #1;
        check("abort_no_valid", 32'(core_valid), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("abort_no_valid2", 32'(core_valid), 32'd0);
        check("abort_mem", mem[40], 32'hA5A50028);
        core_xfer('{1'b0, 32'd40, 32'h0, 4'b0000, 32'hA5A50028, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
